// File: rtl/ej32_ls.sv
// ej32_ls: byte-serial big-endian load/store unit with GET/PUT buffer pointers.
// Transfers 1, 2 or 4 bytes over a synchronous byte RAM, one byte per cycle.
module ej32_ls #(
   parameter int TIB  = 'h1000,
   parameter int OBUF = 'h1400,
   parameter int ASZ  = 17
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req,
   input  logic [2:0]     op,
   input  logic [ASZ-1:0] addr,
   input  logic [31:0]    wdata,
   output logic           busy,
   output logic           done,
   output logic [31:0]    rdata,
   output logic [ASZ-1:0] mem_a,
   output logic           mem_we,
   output logic [7:0]     mem_do,
   input  logic [7:0]     mem_di
);
   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
   localparam logic [ASZ-1:0] one = 1;
   state_t state, state_n;
   logic [2:0] op_q;
   logic [1:0] cnt, n1;
   logic [31:0] wd_q, aligned, fin;
   logic [23:0] acc;
   logic [ASZ-1:0] base, tib_ptr, obuf_ptr;
   logic prev_xfer, load;
   always_comb begin
      state_n = state == IDLE ? (req ? XFER : IDLE) : state == XFER ? (cnt == 2'd0 ? DONE : XFER) : IDLE;
      n1 = (op == 3'd0 || op == 3'd3) ? 2'd3 : (op == 3'd1 || op == 3'd4) ? 2'd1 : 2'd0;
      // store field left-aligned so its most-significant byte goes out first
      aligned = n1 == 2'd3 ? wdata : n1 == 2'd1 ? {wdata[15:0], 16'h0} : {wdata[7:0], 24'h0};
      base = op == 3'd6 ? tib_ptr : op == 3'd7 ? obuf_ptr : addr;
      load = !(op_q inside {3'd3, 3'd4, 3'd5, 3'd7});
      fin = {acc, mem_di};
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rdata     <= '0;
         mem_a     <= '0;
         mem_we    <= 1'b0;
         mem_do    <= '0;
         tib_ptr   <= ASZ'(TIB);
         obuf_ptr  <= ASZ'(OBUF);
         op_q      <= '0;
         cnt       <= '0;
         wd_q      <= '0;
         acc       <= '0;
         prev_xfer <= 1'b0;
      end else begin
         state     <= state_n;
         busy      <= state_n != IDLE;
         done      <= state == XFER && cnt == 2'd0;
         prev_xfer <= state == XFER;
         // RAM data lags the address by one cycle
         if (prev_xfer && load) acc <= fin[23:0];
         if (state == IDLE && req) begin
            op_q   <= op;
            cnt    <= n1;
            mem_a  <= base;
            mem_we <= op inside {3'd3, 3'd4, 3'd5, 3'd7};
            mem_do <= aligned[31:24];
            wd_q   <= {aligned[23:0], 8'h0};
         end else if (state == XFER) begin
            if (cnt != 2'd0) begin
               cnt    <= cnt - 2'd1;
               mem_a  <= mem_a + one;
               mem_do <= wd_q[31:24];
               wd_q   <= {wd_q[23:0], 8'h0};
            end else begin
               mem_we <= 1'b0;
            end
         end
         if (state == DONE) begin
            if (load)
               rdata <= op_q == 3'd0 ? fin :
                        op_q == 3'd1 ? {{16{fin[15]}}, fin[15:0]} :
                        op_q == 3'd2 ? {{24{fin[7]}}, fin[7:0]} : {24'h0, fin[7:0]};
            if (op_q == 3'd6) tib_ptr <= tib_ptr + one;
            if (op_q == 3'd7) obuf_ptr <= obuf_ptr + one;
         end
      end
   end
endmodule

// File: tb/tb_ej32_ls.sv
// tb_ej32_ls: randomized and directed checks of ej32_ls against a byte-RAM model
// and a transaction-level reference of loads, stores, GET and PUT.
module tb_ej32_ls;
   localparam int MSZ = 1 << 17;
   logic clk = 0, rst = 0, req = 0;
   logic [2:0] op = 0;
   logic [16:0] addr = 0;
   logic [31:0] wdata = 0;
   logic busy, done, mem_we;
   logic [31:0] rdata;
   logic [16:0] mem_a;
   logic [7:0] mem_do, mem_di;
   logic [7:0] mem [0:MSZ-1];
   int checks = 0, errors = 0;
   logic [16:0] m_tib, m_obuf;
   logic [31:0] m_rdata;
   logic [16:0] obs_a [1:8];
   logic obs_we [1:8];
   logic [7:0] obs_do [1:8];
   int obs_lat;
   logic [31:0] obs_rd;

   ej32_ls dut (.clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
                .busy(busy), .done(done), .rdata(rdata), .mem_a(mem_a), .mem_we(mem_we),
                .mem_do(mem_do), .mem_di(mem_di));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) mem[mem_a] <= mem_do;
      mem_di <= mem[mem_a];
   end

   function automatic int nb(input logic [2:0] o);
      return (o == 0 || o == 3) ? 4 : (o == 1 || o == 4) ? 2 : 1;
   endfunction

   function automatic logic is_st(input logic [2:0] o);
      return o == 3 || o == 4 || o == 5 || o == 7;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] o, input logic [16:0] b);
      logic [31:0] v = 0;
      for (int i = 0; i < nb(o); i++) v = (v << 8) | 32'(mem[b + 17'(i)]);
      if (o == 1 && v[15]) v = v | 32'hFFFF0000;
      if (o == 2 && v[7]) v = v | 32'hFFFFFF00;
      return v;
   endfunction

   task automatic run_op(input logic [2:0] o, input logic [16:0] a, input logic [31:0] wd);
      @(negedge clk);
      req = 1; op = o; addr = a; wdata = wd;
      @(posedge clk);
      #1 req = 0;
      obs_lat = 0;
      for (int k = 1; k <= 8 && obs_lat == 0; k++) begin
         @(negedge clk);
         obs_a[k] = mem_a; obs_we[k] = mem_we; obs_do[k] = mem_do;
         if (done) obs_lat = k;
      end
      @(negedge clk);
      obs_rd = rdata;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      m_tib = 17'h1000; m_obuf = 17'h1400; m_rdata = 0;
   endtask

   task automatic test_reset();
      #1 rst = 1;
      #2;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rdata); end
      checks++; if (mem_a !== 17'h0) begin errors++; $display("FAIL rst_mem_a got %h exp 0", mem_a); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
      checks++; if (mem_do !== 8'h0) begin errors++; $display("FAIL rst_mem_do got %h exp 0", mem_do); end
      repeat (2) @(negedge clk);
      rst = 0;
      m_tib = 17'h1000; m_obuf = 17'h1400; m_rdata = 0;
   endtask

   task automatic test_directed();
      mem[32'h20] = 8'h12; mem[32'h21] = 8'h34; mem[32'h22] = 8'h56; mem[32'h23] = 8'h78;
      run_op(0, 17'h20, 0);
      for (int k = 1; k <= 4; k++) begin
         checks++; if (obs_a[k] !== 17'(32'h20 + k - 1)) begin errors++; $display("FAIL ldw_addr%0d got %h exp %h", k, obs_a[k], 32'h20 + k - 1); end
      end
      checks++; if (obs_lat !== 5) begin errors++; $display("FAIL ldw_lat got %0d exp 5", obs_lat); end
      checks++; if (obs_rd !== 32'h12345678) begin errors++; $display("FAIL ldw_rdata got %h exp 12345678", obs_rd); end
      mem[32'h30] = 8'hFF; mem[32'h31] = 8'h80;
      run_op(1, 17'h30, 0);
      checks++; if (obs_lat !== 3) begin errors++; $display("FAIL ldh_lat got %0d exp 3", obs_lat); end
      checks++; if (obs_rd !== 32'hFFFFFF80) begin errors++; $display("FAIL ldh_rdata got %h exp ffffff80", obs_rd); end
      run_op(2, 17'h31, 0);
      checks++; if (obs_lat !== 2) begin errors++; $display("FAIL ldb_lat got %0d exp 2", obs_lat); end
      checks++; if (obs_rd !== 32'hFFFFFF80) begin errors++; $display("FAIL ldb31_rdata got %h exp ffffff80", obs_rd); end
      run_op(2, 17'h30, 0);
      checks++; if (obs_rd !== 32'hFFFFFFFF) begin errors++; $display("FAIL ldb30_rdata got %h exp ffffffff", obs_rd); end
      run_op(3, 17'h1FFFE, 32'hAABBCCDD);
      checks++; if (mem[32'h1FFFE] !== 8'hAA) begin errors++; $display("FAIL stw_b0 got %h exp aa", mem[32'h1FFFE]); end
      checks++; if (mem[32'h1FFFF] !== 8'hBB) begin errors++; $display("FAIL stw_b1 got %h exp bb", mem[32'h1FFFF]); end
      checks++; if (mem[0] !== 8'hCC) begin errors++; $display("FAIL stw_b2 got %h exp cc", mem[0]); end
      checks++; if (mem[1] !== 8'hDD) begin errors++; $display("FAIL stw_b3 got %h exp dd", mem[1]); end
      checks++; if (obs_a[3] !== 17'h0) begin errors++; $display("FAIL stw_wrap_addr got %h exp 0", obs_a[3]); end
      checks++; if (obs_we[5] !== 1'b0) begin errors++; $display("FAIL stw_we_done got %b exp 0", obs_we[5]); end
      checks++; if (obs_rd !== 32'hFFFFFFFF) begin errors++; $display("FAIL stw_rdata_hold got %h exp ffffffff", obs_rd); end
   endtask

   task automatic test_getput();
      do_reset();
      mem[32'h1000] = 8'h41; mem[32'h1001] = 8'h42;
      run_op(6, 0, 0);
      checks++; if (obs_a[1] !== 17'h1000) begin errors++; $display("FAIL get1_addr got %h exp 1000", obs_a[1]); end
      checks++; if (obs_rd !== 32'h41) begin errors++; $display("FAIL get1_rdata got %h exp 41", obs_rd); end
      run_op(6, 0, 0);
      checks++; if (obs_a[1] !== 17'h1001) begin errors++; $display("FAIL get2_addr got %h exp 1001", obs_a[1]); end
      checks++; if (obs_rd !== 32'h42) begin errors++; $display("FAIL get2_rdata got %h exp 42", obs_rd); end
      run_op(7, 0, 32'h123456AB);
      checks++; if (obs_a[1] !== 17'h1400) begin errors++; $display("FAIL put1_addr got %h exp 1400", obs_a[1]); end
      checks++; if (mem[32'h1400] !== 8'hAB) begin errors++; $display("FAIL put1_byte got %h exp ab", mem[32'h1400]); end
      checks++; if (obs_rd !== 32'h42) begin errors++; $display("FAIL put_rdata_hold got %h exp 42", obs_rd); end
      run_op(7, 0, 32'h00000099);
      checks++; if (obs_a[1] !== 17'h1401) begin errors++; $display("FAIL put2_addr got %h exp 1401", obs_a[1]); end
      checks++; if (mem[32'h1401] !== 8'h99) begin errors++; $display("FAIL put2_byte got %h exp 99", mem[32'h1401]); end
      m_tib = 17'h1002; m_obuf = 17'h1402; m_rdata = 32'h42;
   endtask

   task automatic test_back_to_back();
      mem[32'h31] = 8'h80;
      @(negedge clk);
      req = 1; op = 2; addr = 17'h31;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         checks++; if (busy !== (c % 3 != 0)) begin errors++; $display("FAIL b2b_busy c%0d got %b exp %b", c, busy, c % 3 != 0); end
         checks++; if (done !== (c % 3 == 2)) begin errors++; $display("FAIL b2b_done c%0d got %b exp %b", c, done, c % 3 == 2); end
      end
      req = 0;
      @(negedge clk);
      req = 1;
      @(posedge clk);
      #1 req = 0;
      repeat (2) @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL pulse_done got %b exp 1", done); end
      req = 1;
      @(posedge clk);
      #1 req = 0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pulse_ignored c%0d busy got %b exp 0", c, busy); end
      end
      m_rdata = 32'hFFFFFF80;
   endtask

   task automatic test_reset_mid();
      int dones = 0;
      mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
      @(negedge clk);
      req = 1; op = 3; addr = 17'h100; wdata = 32'hA1B2C3D4;
      @(posedge clk);
      #1 req = 0;
      @(posedge clk);
      #2 rst = 1;
      #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rmid_we got %b exp 0", mem_we); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
      repeat (2) @(negedge clk);
      rst = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (done) dones++;
      end
      checks++; if (dones != 0) begin errors++; $display("FAIL rmid_done got %0d pulses exp 0", dones); end
      checks++; if (mem[32'h100] !== 8'hA1) begin errors++; $display("FAIL rmid_b0 got %h exp a1", mem[32'h100]); end
      checks++; if (mem[32'h101] !== 8'h22) begin errors++; $display("FAIL rmid_b1 got %h exp 22", mem[32'h101]); end
      checks++; if (mem[32'h102] !== 8'h33) begin errors++; $display("FAIL rmid_b2 got %h exp 33", mem[32'h102]); end
      m_tib = 17'h1000; m_obuf = 17'h1400;
      run_op(2, 17'h100, 0);
      checks++; if (obs_lat !== 2) begin errors++; $display("FAIL rmid_next_lat got %0d exp 2", obs_lat); end
      checks++; if (obs_rd !== 32'hFFFFFFA1) begin errors++; $display("FAIL rmid_next_rdata got %h exp ffffffa1", obs_rd); end
      m_rdata = 32'hFFFFFFA1;
   endtask

   task automatic test_random();
      logic [2:0] o;
      logic [16:0] a, b;
      logic [31:0] wd, exp;
      logic [7:0] eb [4];
      int n;
      repeat (60) begin
         o = 3'($urandom_range(0, 7));
         a = ($urandom & 1) ? 17'h1FFFC + 17'($urandom_range(0, 3)) : 17'($urandom);
         wd = $urandom;
         n = nb(o);
         b = o == 6 ? m_tib : o == 7 ? m_obuf : a;
         exp = is_st(o) ? m_rdata : ref_load(o, b);
         for (int i = 0; i < n; i++) eb[i] = 8'(wd >> (8 * (n - 1 - i)));
         run_op(o, a, wd);
         checks++; if (obs_lat !== n + 1) begin errors++; $display("FAIL rnd_lat op%0d got %0d exp %0d", o, obs_lat, n + 1); end
         for (int k = 1; k <= n; k++) begin
            checks++; if (obs_a[k] !== b + 17'(k - 1)) begin errors++; $display("FAIL rnd_addr op%0d k%0d got %h exp %h", o, k, obs_a[k], b + 17'(k - 1)); end
            checks++; if (obs_we[k] !== is_st(o)) begin errors++; $display("FAIL rnd_we op%0d k%0d got %b exp %b", o, k, obs_we[k], is_st(o)); end
            if (is_st(o)) begin
               checks++; if (obs_do[k] !== eb[k-1]) begin errors++; $display("FAIL rnd_do op%0d k%0d got %h exp %h", o, k, obs_do[k], eb[k-1]); end
               checks++; if (mem[b + 17'(k - 1)] !== eb[k-1]) begin errors++; $display("FAIL rnd_mem op%0d k%0d got %h exp %h", o, k, mem[b + 17'(k - 1)], eb[k-1]); end
            end
         end
         checks++; if (obs_we[n+1] !== 1'b0) begin errors++; $display("FAIL rnd_we_done op%0d got %b exp 0", o, obs_we[n+1]); end
         checks++; if (obs_rd !== exp) begin errors++; $display("FAIL rnd_rdata op%0d got %h exp %h", o, obs_rd, exp); end
         m_rdata = exp;
         if (o == 6) m_tib = m_tib + 17'd1;
         if (o == 7) m_obuf = m_obuf + 17'd1;
      end
   endtask

   initial begin
      for (int i = 0; i < MSZ; i++) mem[i] = 8'($urandom);
      test_reset();
      test_directed();
      test_getput();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ej32_ls.md
EJ32_LS -- requirements
Module: ej32_ls

Interface
REQ-001 Parameter TIB, default 'h1000, reset value of the GET input-buffer pointer.
REQ-002 Parameter OBUF, default 'h1400, reset value of the PUT output-buffer pointer.
REQ-003 Parameter ASZ, default 17, byte-address width.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port req  input  1  request strobe; sampled only in IDLE.
REQ-007 Port op  input  3  operation: 0 LDW, 1 LDH, 2 LDB, 3 STW, 4 STH, 5 STB, 6 GET, 7 PUT.
REQ-008 Port addr  input  ASZ  byte address for ops 0-5.
REQ-009 Port wdata  input  32  store data.
REQ-010 Port busy  output  1  high in every state other than IDLE.
REQ-011 Port done  output  1  single-cycle completion pulse.
REQ-012 Port rdata  output  32  load result.
REQ-013 Port mem_a  output  ASZ  byte-memory address.
REQ-014 Port mem_we  output  1  byte-memory write enable.
REQ-015 Port mem_do  output  8  byte-memory write data.
REQ-016 Port mem_di  input  8  byte-memory read data, valid one cycle after mem_a is presented (synchronous RAM).

Function
REQ-017 The state machine SHALL have three states: IDLE, XFER and DONE.
REQ-018 IDLE->XFER on req=1; op, addr and wdata latched (cycle 0); byte count N = 4 (LDW/STW), 2 (LDH/STH), 1 (LDB/STB/GET/PUT).
REQ-019 XFER SHALL last exactly N cycles (cycles 1..N); cycle k presents mem_a = base+k-1, base = latched addr, or tib_ptr for GET, or obuf_ptr for PUT.
REQ-020 Address arithmetic SHALL wrap modulo 2^ASZ.
REQ-021 Byte order SHALL be big-endian: most-significant byte at the lowest address, for both loads and stores.
REQ-022 Stores: mem_we=1 in cycles 1..N only; mem_do = byte k of latched wdata (MSB of the N-byte field first); PUT writes wdata[7:0].
REQ-023 Loads: mem_we=0; mem_di sampled in cycles 2..N+1 and shifted into an accumulator.
REQ-024 XFER->DONE after cycle N; DONE lasts one cycle (cycle N+1), done=1, then DONE->IDLE unconditionally.
REQ-025 rdata SHALL update at the end of the DONE cycle for loads: LDW full word; LDH sign-extended from bit 15; LDB sign-extended from bit 7; GET zero-extended.
REQ-026 rdata SHALL hold its value through stores and idle cycles.
REQ-027 Latency from req acceptance to done: LDW/STW 5 cycles, LDH/STH 3 cycles, byte ops 2 cycles.
REQ-028 req while busy=1, including during DONE, SHALL be ignored (no queuing); a new request is accepted in the first IDLE cycle.
REQ-029 tib_ptr SHALL increment by 1 in the GET DONE cycle; obuf_ptr SHALL increment by 1 in the PUT DONE cycle; both wrap modulo 2^ASZ.
REQ-030 In IDLE, mem_we=0 and mem_a holds its last value.
REQ-031 Outputs SHALL be registered; busy SHALL rise the cycle after acceptance.

Reset
REQ-032 rst=1 SHALL force IDLE immediately, regardless of clk.
REQ-033 Reset values: busy=0, done=0, rdata=0, mem_a=0, mem_we=0, mem_do=0, tib_ptr=TIB, obuf_ptr=OBUF.
REQ-034 Reset in mid-XFER SHALL drop mem_we within the same cycle; no further memory writes occur, and no done is produced for the aborted operation.

Verification
REQ-035 Memory 0x20..0x23 = 12 34 56 78; LDW addr 0x20 -> mem_a 0x20,0x21,0x22,0x23 in cycles 1-4; done in cycle 5; rdata=0x12345678.
REQ-036 Memory 0x30..0x31 = FF 80; LDH addr 0x30 -> rdata=0xFFFFFF80 in cycle 3; then LDB addr 0x31 -> rdata=0xFFFFFF80; LDB addr 0x30 -> 0xFFFFFFFF.
REQ-037 STW addr 0x1FFFE, wdata 0xAABBCCDD -> writes AA@0x1FFFE, BB@0x1FFFF, CC@0x00000, DD@0x00001 (wrap); rdata unchanged.
REQ-038 After reset, GET twice with TIB bytes 41 42 -> rdata 0x41, then 0x42; mem_a 0x1000 then 0x1001; PUT wdata 0x123456AB -> byte AB written at 0x1400, next PUT at 0x1401.
REQ-039 req held high continuously -> back-to-back LDB ops accepted every 3 cycles; a req pulse during DONE alone -> not accepted.
REQ-040 rst asserted in cycle 2 of STW -> mem_we low immediately; only one byte written; busy=0, done stays 0; next req accepted normally.
